cpu_phase_gen: RTL and testbench

- Parametrised CPU bus-phase generator for the 68k wrapper; replaces the fixed `ph1 = c1&c3`, `ph2 = !c1&!c3` logic in the top level.
- Derives one-cycle `cpu_ph1`/`cpu_ph2` pulses from the clk_sys domain, phase-locked to the amiga_clk `c1`/`c3` quadrature.
- Adds selectable CPU speed (7 / 14 MHz / slowed), glitch-free speed switching, wait-state stalls and lock supervision.
- Mode 0 is bit-exact with the existing phase logic.

---
 rtl/cpu_phase_gen.sv | 134 +++++++++++++
 tb/tb_cpu_phase_gen.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/cpu_phase_gen.sv
// 68k bus-phase generator: one-cycle cpu_ph1/cpu_ph2 pulses on clk_sys, phase-locked to c1/c3.
// Pulses are registered (1 cycle after their slot); stall defers ph1 to the next slot of the mode.
module cpu_phase_gen #(
  parameter int RESET_HOLD = 8,
  parameter int SLOW_SHIFT = 1
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       c1,
  input  logic       c3,
  input  logic [1:0] speed,
  input  logic       stall,
  output logic       cpu_ph1,
  output logic       cpu_ph2,
  output logic       cycle_start,
  output logic [1:0] speed_cur,
  output logic       switching,
  output logic       locked
);

  localparam int SW = SLOW_SHIFT + 2;
  localparam int HW = $clog2(RESET_HOLD + 2);
  localparam logic [HW-1:0] HOLD_MAX = HW'(RESET_HOLD);
  localparam logic [SW-1:0] SLOW_PH2 = SW'(2 << SLOW_SHIFT);

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    ALIGN    = 2'd1,
    LOCKED   = 2'd2
  } lock_state_t;

  lock_state_t   lock_state;
  lock_state_t   lock_state_nxt;
  logic [SW-1:0] slot;
  logic [SW-1:0] slot_eff;
  logic [2:0]    gap;
  logic [2:0]    gap_nxt;
  logic [HW-1:0] hold_cnt;
  logic          pend;
  logic          sync;
  logic          lock_loss;
  logic          hold_done;
  logic          apply_sw;
  logic [1:0]    speed_map;
  logic [1:0]    mode;
  logic          ph1_slot;
  logic          ph2_slot;
  logic          ph1_fire;
  logic          ph2_fire;

  assign locked = (lock_state == LOCKED);

  // slot_eff is the slot value as seen this cycle: c1&&c3 forces the low bits to 0.
  always_comb begin
    sync      = c1 & c3;
    slot_eff  = sync ? {slot[SW-1:2], 2'b00} : slot;
    speed_map = (speed == 2'd3) ? 2'd0 : speed;
    lock_loss = sync && (slot[1:0] != 2'b00);
    hold_done = (hold_cnt == HOLD_MAX);
    gap_nxt   = sync ? 3'd0 : ((gap == 3'd7) ? gap : gap + 3'd1);
    apply_sw  = switching && (speed_map != speed_cur) && sync && !pend && (slot_eff == '0);
    mode      = apply_sw ? speed_map : speed_cur;

    ph1_slot = 1'b0;
    ph2_slot = 1'b0;
    case (mode)
      2'd1: begin
        ph1_slot = !slot_eff[0];
        ph2_slot = slot_eff[0];
      end
      2'd2: begin
        ph1_slot = (slot_eff == '0);
        ph2_slot = (slot_eff == SLOW_PH2);
      end
      default: begin
        ph1_slot = (slot_eff[1:0] == 2'd0);
        ph2_slot = (slot_eff[1:0] == 2'd2);
      end
    endcase

    // A misaligned c1&&c3 blocks ph1 in the very cycle it is detected.
    ph1_fire = ph1_slot && !pend && !stall && hold_done && locked && !lock_loss;
    ph2_fire = ph2_slot && pend;
  end

  always_comb begin
    lock_state_nxt = lock_state;
    case (lock_state)
      UNLOCKED: if (sync) lock_state_nxt = ALIGN;
      ALIGN:    if (sync && (gap == 3'd3)) lock_state_nxt = LOCKED;
      LOCKED:   if (lock_loss) lock_state_nxt = UNLOCKED;
      default:  lock_state_nxt = UNLOCKED;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      lock_state <= UNLOCKED;
    end else begin
      lock_state <= lock_state_nxt;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      slot        <= '0;
      gap         <= '0;
      hold_cnt    <= '0;
      pend        <= 1'b0;
      cpu_ph1     <= 1'b0;
      cpu_ph2     <= 1'b0;
      cycle_start <= 1'b0;
      speed_cur   <= 2'd0;
      switching   <= 1'b0;
    end else begin
      slot        <= slot_eff + SW'(1);
      gap         <= gap_nxt;
      hold_cnt    <= hold_done ? hold_cnt : hold_cnt + HW'(1);
      pend        <= ph1_fire ? 1'b1 : (ph2_fire ? 1'b0 : pend);
      cpu_ph1     <= ph1_fire;
      cpu_ph2     <= ph2_fire;
      cycle_start <= ph1_fire;
      if (apply_sw) begin
        speed_cur <= speed_map;
      end
      // Latest request wins; a request that returns to speed_cur simply clears.
      switching   <= apply_sw ? 1'b0 : (speed_map != speed_cur);
    end
  end

  a_ph_excl: assert property (@(posedge clk_sys) disable iff (reset) !(cpu_ph1 && cpu_ph2));
  a_speed_ok: assert property (@(posedge clk_sys) disable iff (reset) speed_cur != 2'd3);

endmodule

// File: tb/tb_cpu_phase_gen.sv
// Directed bench for cpu_phase_gen: drives c1/c3 quadrature and checks pulses against hand-derived timing.
module tb_cpu_phase_gen;

  logic       clk_sys;
  logic       reset;
  logic       c1;
  logic       c3;
  logic [1:0] speed;
  logic       stall;
  logic       cpu_ph1;
  logic       cpu_ph2;
  logic       cycle_start;
  logic [1:0] speed_cur;
  logic       switching;
  logic       locked;

  int   ph = 0;
  int   pp = 0;
  logic pc = 1'b0;
  logic pn = 1'b0;
  logic inject = 1'b0;
  int   n_chk = 0;
  int   n_pass = 0;
  int   ph2_cnt = 0;

  cpu_phase_gen #(.RESET_HOLD(8), .SLOW_SHIFT(1)) dut (
    .clk_sys     (clk_sys),
    .reset       (reset),
    .c1          (c1),
    .c3          (c3),
    .speed       (speed),
    .stall       (stall),
    .cpu_ph1     (cpu_ph1),
    .cpu_ph2     (cpu_ph2),
    .cycle_start (cycle_start),
    .speed_cur   (speed_cur),
    .switching   (switching),
    .locked      (locked)
  );

  initial begin
    clk_sys = 1'b0;
    forever #5 clk_sys = ~clk_sys;
  end

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  // Quadrature: c1 = 1100, c3 = 0110, so c1&&c3 at phase 1 and !c1&&!c3 at phase 3.
  task automatic step();
    c1 = (ph == 0) || (ph == 1) || inject;
    c3 = (ph == 1) || (ph == 2);
    pc = c1 && c3;
    pn = !c1 && !c3;
    pp = ph;
    @(posedge clk_sys);
    #1;
    ph = (ph + 1) % 4;
  endtask

  task automatic wait_speed(input logic [1:0] tgt);
    for (int i = 0; i < 17 && speed_cur != tgt; i++) step();
  endtask

  initial begin
    reset = 1'b1;
    speed = 2'd0;
    stall = 1'b0;
    c1    = 1'b0;
    c3    = 1'b0;
    repeat (3) step();
    chk_eq("rst_pulses", {cpu_ph1, cpu_ph2, cycle_start}, 0);
    chk_eq("rst_locked", locked, 0);
    chk_eq("rst_speed_cur", speed_cur, 0);
    chk_eq("rst_switching", switching, 0);

    // Release: 1st c1&&c3 at r=2, lock on 2nd at r=6, hold ends r=8, first ph1 slot r=10.
    reset = 1'b0;
    for (int r = 0; r < 12; r++) begin
      step();
      chk_eq("lock_time", locked, r >= 6);
      chk_eq("first_ph1", cpu_ph1, r == 10);
      chk_eq("early_ph2", cpu_ph2, 0);
    end

    for (int i = 0; i < 1000; i++) begin
      step();
      chk_eq("m0_bitexact", {cpu_ph1, cpu_ph2, cycle_start}, {pc, pn, pc});
    end

    speed = 2'd1;
    step();
    chk_eq("sw1_pending", switching, 1);
    chk_eq("sw1_not_yet", speed_cur, 0);
    wait_speed(2'd1);
    chk_eq("sw1_speed_cur", speed_cur, 1);
    chk_eq("sw1_switching", switching, 0);
    chk_eq("sw1_ph1_at_apply", cpu_ph1, 1);
    for (int i = 0; i < 16; i++) begin
      step();
      chk_eq("m1_ph1", cpu_ph1, (pp == 1) || (pp == 3));
      chk_eq("m1_ph2", cpu_ph2, (pp == 0) || (pp == 2));
    end

    speed = 2'd2;
    wait_speed(2'd2);
    chk_eq("sw2_speed_cur", speed_cur, 2);
    chk_eq("sw2_switching", switching, 0);
    chk_eq("sw2_ph1_at_apply", cpu_ph1, 1);
    for (int j = 1; j <= 16; j++) begin
      step();
      chk_eq("m2_ph1", cpu_ph1, (j % 8) == 0);
      chk_eq("m2_ph2", cpu_ph2, (j % 8) == 4);
    end

    speed = 2'd0;
    step();
    chk_eq("tog_switching_up", switching, 1);
    chk_eq("tog_speed_hold1", speed_cur, 2);
    speed = 2'd2;
    step();
    chk_eq("tog_switching_down", switching, 0);
    chk_eq("tog_speed_hold2", speed_cur, 2);
    for (int i = 0; i < 8; i++) begin
      step();
      chk_eq("tog_speed_stays", speed_cur, 2);
      chk_eq("tog_quiet", switching, 0);
    end

    speed = 2'd3;
    wait_speed(2'd0);
    chk_eq("sw3_speed_cur", speed_cur, 0);
    chk_eq("sw3_switching", switching, 0);
    chk_eq("sw3_ph1_at_apply", cpu_ph1, 1);
    step();
    chk_eq("sw3_stays_quiet", switching, 0);

    // Stall spans phases 3,0,1,2,3,0,1: two ph1 slots suppressed, the pending ph2 still goes out.
    while (ph != 3) step();
    for (int k = 0; k < 13; k++) begin
      stall = (k < 7);
      step();
      chk_eq("stall_ph1", cpu_ph1, k == 10);
      chk_eq("stall_ph2", cpu_ph2, (k == 0) || (k == 12));
    end
    stall = 1'b0;

    // Misaligned c1&&c3 at slot 1: unlock, one trailing ph2, relock 4+4 cycles on, ph1 resumes.
    while (ph != 2) step();
    ph2_cnt = 0;
    for (int i = 0; i < 23; i++) begin
      inject = (i == 0);
      step();
      inject = 1'b0;
      if (i <= 10) begin
        chk_eq("ll_locked", locked, i >= 7);
        chk_eq("ll_no_ph1", cpu_ph1, 0);
        ph2_cnt += int'(cpu_ph2);
      end else begin
        chk_eq("ll_resume", {cpu_ph1, cpu_ph2, cycle_start}, {pc, pn, pc});
      end
    end
    chk_eq("ll_trailing_ph2", ph2_cnt, 1);

    // Reset lands between a mode-1 ph1 and its ph2.
    speed = 2'd1;
    wait_speed(2'd1);
    chk_eq("rm_speed_cur", speed_cur, 1);
    chk_eq("rm_ph1_before", cpu_ph1, 1);
    reset = 1'b1;
    speed = 2'd0;
    step();
    chk_eq("rm_pulses", {cpu_ph1, cpu_ph2, cycle_start}, 0);
    chk_eq("rm_speed_cur0", speed_cur, 0);
    chk_eq("rm_locked", locked, 0);
    chk_eq("rm_switching", switching, 0);
    reset = 1'b0;
    for (int r = 0; r < 13; r++) begin
      step();
      chk_eq("rm_ph1", cpu_ph1, r == 10);
      chk_eq("rm_ph2", cpu_ph2, r == 12);
      chk_eq("rm_lock", locked, r >= 6);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
